// File: rtl/conv_sequencer.sv
// Convolution control sequencer: run-time configured kernel load, line-buffer fill,
// raster streaming with stride/padding, pipeline drain and per-channel iteration.
module conv_sequencer #(
    parameter int MAX_WIDTH    = 128,
    parameter int MAX_HEIGHT   = 128,
    parameter int MAX_CHANNELS = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int PIPE_LAT     = 2,
    parameter int MEM_AW       = 15,
    localparam int W_AW = $clog2(MAX_WIDTH),
    localparam int H_AW = $clog2(MAX_HEIGHT),
    localparam int C_AW = $clog2(MAX_CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W_AW:0]     cfg_width,
    input  logic [H_AW:0]     cfg_height,
    input  logic [C_AW:0]     cfg_channels,
    input  logic              cfg_stride,
    input  logic              cfg_pad,
    input  logic [MEM_AW-1:0] addr_image,
    input  logic [MEM_AW-1:0] addr_kernel,
    input  logic [MEM_AW-1:0] addr_conv,
    input  logic              stall,
    output logic              rd_en,
    output logic [MEM_AW-1:0] rd_addr,
    output logic              kernel_mode,
    output logic              pad_zero,
    output logic              win_valid,
    output logic [H_AW-1:0]   win_row,
    output logic [W_AW-1:0]   win_col,
    output logic [C_AW-1:0]   chan,
    output logic              wr_en,
    output logic [MEM_AW-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] KS   = 32'(KERNEL_SIZE);
    localparam logic [31:0] K1   = 32'(KERNEL_SIZE - 1);
    localparam logic [31:0] KK   = 32'(KERNEL_SIZE * KERNEL_SIZE);
    localparam logic [31:0] PADK = 32'((KERNEL_SIZE - 1) / 2);
    localparam logic [31:0] LAT1 = 32'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_KLOAD, S_FILL, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [31:0]       r_w, r_h, r_c;
    logic              r_s, r_pad;
    logic [MEM_AW-1:0] r_ai, r_ak, r_ac;
    logic [C_AW:0]     r_chan;
    logic [31:0]       r_cnt, r_pr, r_pc, r_idx;
    logic              r_err;
    logic [PIPE_LAT-1:0] r_pv;
    logic [MEM_AW-1:0] r_pa [PIPE_LAT];

    logic [31:0] w_padn, w_weff, w_heff, w_outw, w_outh, w_fill;
    logic [31:0] w_chan32, w_dr, w_dc, w_wrow, w_wcol;
    logic        w_adv, w_scan, w_last_px, w_win, w_is_pad, w_more, w_bad;
    logic [MEM_AW-1:0] w_waddr, w_iaddr, w_kaddr;

    // Geometry of the padded scan, derived from the latched configuration
    assign w_padn   = r_pad ? PADK : 32'd0;
    assign w_weff   = r_w + (w_padn << 1);
    assign w_heff   = r_h + (w_padn << 1);
    assign w_outw   = r_pad ? ((r_w + 32'(r_s)) >> r_s) : (((r_w - KS) >> r_s) + 32'd1);
    assign w_outh   = r_pad ? ((r_h + 32'(r_s)) >> r_s) : (((r_h - KS) >> r_s) + 32'd1);
    assign w_fill   = K1 * w_weff + KS;
    assign w_chan32 = 32'(r_chan);

    assign w_adv     = !stall || (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_scan    = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_last_px = (r_pr == w_heff - 32'd1) && (r_pc == w_weff - 32'd1);
    assign w_more    = (w_chan32 + 32'd1) < r_c;

    // A window completes on the read of its bottom-right pixel
    assign w_dr   = r_pr - K1;
    assign w_dc   = r_pc - K1;
    assign w_win  = w_scan && (r_pr >= K1) && (r_pc >= K1) && !(r_s && (w_dr[0] || w_dc[0]));
    assign w_wrow = w_dr >> r_s;
    assign w_wcol = w_dc >> r_s;

    assign w_is_pad = (r_pr < w_padn) || (r_pr >= r_h + w_padn) ||
                      (r_pc < w_padn) || (r_pc >= r_w + w_padn);

    assign w_waddr = MEM_AW'(32'(r_ac) + w_chan32 * w_outw * w_outh + w_wrow * w_outw + w_wcol);
    assign w_iaddr = MEM_AW'(32'(r_ai) + w_chan32 * r_w * r_h +
                     (w_is_pad ? 32'd0 : (r_pr - w_padn) * r_w + (r_pc - w_padn)));
    assign w_kaddr = MEM_AW'(32'(r_ak) + w_chan32 * KK + r_cnt);

    assign w_bad = (r_c == 32'd0) || (r_c > 32'(MAX_CHANNELS)) ||
                   (r_w > 32'(MAX_WIDTH)) || (r_h > 32'(MAX_HEIGHT)) ||
                   (r_pad ? ((r_w == 32'd0) || (r_h == 32'd0)) : ((r_w < KS) || (r_h < KS)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_adv) begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_CHECK;
                S_CHECK: w_next = w_bad ? S_IDLE : S_KLOAD;
                S_KLOAD: if (r_cnt == KK - 32'd1) w_next = S_FILL;
                S_FILL: begin
                    if (w_last_px)                      w_next = S_DRAIN;
                    else if (r_idx == w_fill - 32'd1)   w_next = S_RUN;
                end
                S_RUN:   if (w_last_px) w_next = S_DRAIN;
                S_DRAIN: if (r_cnt == LAT1) w_next = w_more ? S_KLOAD : S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w <= '0; r_h <= '0; r_c <= '0; r_s <= 1'b0; r_pad <= 1'b0;
            r_ai <= '0; r_ak <= '0; r_ac <= '0;
            r_chan <= '0; r_cnt <= '0; r_pr <= '0; r_pc <= '0; r_idx <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_adv) begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_w <= 32'(cfg_width); r_h <= 32'(cfg_height); r_c <= 32'(cfg_channels);
                        r_s <= cfg_stride; r_pad <= cfg_pad;
                        r_ai <= addr_image; r_ak <= addr_kernel; r_ac <= addr_conv;
                        r_chan <= '0; r_cnt <= '0;
                    end
                    S_CHECK: begin
                        r_err <= w_bad;
                        r_cnt <= '0;
                    end
                    S_KLOAD: begin
                        if (r_cnt == KK - 32'd1) begin
                            r_cnt <= '0; r_pr <= '0; r_pc <= '0; r_idx <= '0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    S_FILL, S_RUN: begin
                        r_idx <= r_idx + 32'd1;
                        if (r_pc == w_weff - 32'd1) begin
                            r_pc <= '0;
                            r_pr <= r_pr + 32'd1;
                        end else begin
                            r_pc <= r_pc + 32'd1;
                        end
                    end
                    S_DRAIN: begin
                        if (r_cnt == LAT1) begin
                            r_cnt <= '0;
                            if (w_more) r_chan <= r_chan + {{C_AW{1'b0}}, 1'b1};
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write tracking: valid and address shift PIPE_LAT deep, frozen while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv <= '0;
        end else if (w_adv) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) r_pv[i] <= r_pv[i-1];
            r_pv[0] <= w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) r_pa[i] <= r_pa[i-1];
            r_pa[0] <= w_waddr;
        end
    end

    always_comb begin
        rd_en       = 1'b0;
        rd_addr     = '0;
        pad_zero    = 1'b0;
        win_valid   = 1'b0;
        win_row     = '0;
        win_col     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        err         = r_err;
        kernel_mode = (r_state == S_KLOAD);
        chan        = (r_state != S_IDLE) ? r_chan[C_AW-1:0] : '0;
        if (r_state == S_KLOAD) begin
            rd_en   = !stall;
            rd_addr = w_kaddr;
        end else if (w_scan) begin
            rd_en    = !stall;
            rd_addr  = w_iaddr;
            pad_zero = w_is_pad;
        end
        if (w_win && !stall) begin
            win_valid = 1'b1;
            win_row   = H_AW'(w_wrow);
            win_col   = W_AW'(w_wcol);
        end
        if (r_pv[PIPE_LAT-1] && !stall) begin
            wr_en   = 1'b1;
            wr_addr = r_pa[PIPE_LAT-1];
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed table-driven bench for conv_sequencer: per-run strobe counts and address sums
// against hand-computed values, plus reset and mid-run reset sequences.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_width, cfg_height;
    logic [2:0]  cfg_channels;
    logic        cfg_stride, cfg_pad;
    logic [14:0] addr_image, addr_kernel, addr_conv;
    logic        stall;
    logic        rd_en, kernel_mode, pad_zero, win_valid, wr_en, busy, done, err;
    logic [14:0] rd_addr, wr_addr;
    logic [6:0]  win_row, win_col;
    logic [1:0]  chan;

    conv_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channels(cfg_channels),
        .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
        .addr_image(addr_image), .addr_kernel(addr_kernel), .addr_conv(addr_conv),
        .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .kernel_mode(kernel_mode),
        .pad_zero(pad_zero), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .chan(chan), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, h, c, s, pad, ai, ak, ac, sf, sl;
        int rd, krd, pz, wr, wsum, ksum, isum, mrow, mcol, dn, er, bsy;
    } vec_t;

    vec_t tbl[12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int outs_on();
        return $countones({rd_en, rd_addr, kernel_mode, pad_zero, win_valid, win_row, win_col,
                           chan, wr_en, wr_addr, busy, done, err});
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int rd = 0, krd = 0, pz = 0, wr = 0, wsum = 0, ksum = 0, isum = 0;
        int mrow = 0, mcol = 0, dn = 0, er = 0, bsy = 0, sbad = 0, fin = 0;
        @(negedge clk);
        cfg_width = 8'(v.w); cfg_height = 8'(v.h); cfg_channels = 3'(v.c);
        cfg_stride = v.s[0]; cfg_pad = v.pad[0];
        addr_image = 15'(v.ai); addr_kernel = 15'(v.ak); addr_conv = 15'(v.ac);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            stall = (n >= v.sf) && (n < v.sf + v.sl);
            #1;
            if (rd_en) rd++;
            if (rd_en && kernel_mode) begin krd++; ksum += int'(rd_addr); end
            if (rd_en && pad_zero) pz++;
            if (rd_en && !kernel_mode && !pad_zero) isum += int'(rd_addr);
            if (wr_en) begin wr++; wsum += int'(wr_addr); end
            if (win_valid && int'(win_row) > mrow) mrow = int'(win_row);
            if (win_valid && int'(win_col) > mcol) mcol = int'(win_col);
            if (done) dn++;
            if (err) er++;
            if (busy) bsy++;
            if (stall && (rd_en || wr_en || win_valid)) sbad++;
            if (!busy) begin fin = 1; break; end
            @(negedge clk);
        end
        stall = 1'b0;
        chk({tag, ".finished"}, fin, 1);
        chk({tag, ".rd"}, rd, v.rd);
        chk({tag, ".krd"}, krd, v.krd);
        chk({tag, ".pad"}, pz, v.pz);
        chk({tag, ".wr"}, wr, v.wr);
        chk({tag, ".wsum"}, wsum, v.wsum);
        chk({tag, ".ksum"}, ksum, v.ksum);
        chk({tag, ".isum"}, isum, v.isum);
        chk({tag, ".mrow"}, mrow, v.mrow);
        chk({tag, ".mcol"}, mcol, v.mcol);
        chk({tag, ".done"}, dn, v.dn);
        chk({tag, ".err"}, er, v.er);
        chk({tag, ".busy"}, bsy, v.bsy);
        chk({tag, ".stall_strobe"}, sbad, 0);
    endtask

    initial begin
        //          w h c s p  ai  ak  ac  sf sl | rd krd pz wr wsum ksum isum mr mc dn er bsy
        tbl[0]  = '{4,4,1,0,0, 100,10,200,-1,0, 25,9,0,4,806,126,1720,1,1,1,0,29};
        tbl[1]  = '{5,5,1,1,1, 1000,0,300,-1,0, 58,9,24,9,2736,36,25300,2,2,1,0,62};
        tbl[2]  = '{4,4,3,0,0, 0,40,500,-1,0, 75,27,0,12,6066,1431,1128,1,1,1,0,83};
        tbl[3]  = '{2,4,1,0,0, 0,0,0,-1,0, 0,0,0,0,0,0,0,0,0,0,1,1};
        tbl[4]  = '{4,4,0,0,0, 0,0,0,-1,0, 0,0,0,0,0,0,0,0,0,0,1,1};
        tbl[5]  = '{4,2,1,0,0, 0,0,0,-1,0, 0,0,0,0,0,0,0,0,0,0,1,1};
        tbl[6]  = '{4,4,5,0,0, 0,0,0,-1,0, 0,0,0,0,0,0,0,0,0,0,1,1};
        tbl[7]  = '{3,3,1,0,0, 50,5,7,-1,0, 18,9,0,1,7,81,486,0,0,1,0,22};
        tbl[8]  = '{1,1,1,0,1, 20,0,33,-1,0, 18,9,8,1,33,36,20,0,0,1,0,22};
        tbl[9]  = '{6,4,1,1,0, 0,0,0,-1,0, 33,9,0,2,1,36,276,0,1,1,0,37};
        tbl[10] = '{4,4,1,0,0, 100,10,200,22,5, 25,9,0,4,806,126,1720,1,1,1,0,34};
        tbl[11] = '{4,4,1,0,0, 100,10,200,0,3, 25,9,0,4,806,126,1720,1,1,1,0,32};

        reset = 1'b0; start = 1'b0; stall = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_channels = '0; cfg_stride = 1'b0; cfg_pad = 1'b0;
        addr_image = '0; addr_kernel = '0; addr_conv = '0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", outs_on(), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle.outputs", outs_on(), 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset asserted in the middle of FILL, then a clean rerun
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_channels = 3'd1; cfg_stride = 1'b0; cfg_pad = 1'b0;
        addr_image = 15'd100; addr_kernel = 15'd10; addr_conv = 15'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chk("midfill.busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("midfill.async_outputs", outs_on(), 0);
        @(posedge clk);
        #1;
        chk("midfill.edge_outputs", outs_on(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midfill.idle_outputs", outs_on(), 0);
        run_vec(tbl[0], "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
